// File: rtl/exu_alu_rglr_q.sv
// Regular integer ALU stage (RV32I/RV64I op set) feeding a DEPTH-entry in-order result queue.
// Latency: 1 cycle through the queue; 0 cycles when ALU_RGLR_Q_BYPASS_EN is defined and the queue is empty.
// Backpressure: alu_i_ready drops only when the queue is full; it depends on registered count alone.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   alu_i_*                        issue side: operands, op, select flags, tag, ebreak, flush (valid/ready)
//   alu_o_*                        writeback side: result, tag, ebreak commit flag (valid/ready)
// Optional feature macro: ALU_RGLR_Q_BYPASS_EN (same-cycle bypass when the queue is empty).
module exu_alu_rglr_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAGW  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_i_valid,
    output logic            alu_i_ready,
    input  logic [XLEN-1:0] alu_i_rs1,
    input  logic [XLEN-1:0] alu_i_rs2,
    input  logic [XLEN-1:0] alu_i_imm,
    input  logic [XLEN-1:0] alu_i_pc,
    input  logic [3:0]      alu_i_op,
    input  logic            alu_i_op1pc,
    input  logic            alu_i_op2imm,
    input  logic            alu_i_nop,
    input  logic            alu_i_ebreak,
    input  logic [TAGW-1:0] alu_i_itag,
    input  logic            alu_i_flush,
    output logic            alu_o_valid,
    input  logic            alu_o_ready,
    output logic [XLEN-1:0] alu_o_wbck_wdat,
    output logic [TAGW-1:0] alu_o_itag,
    output logic            alu_o_cmt_ebreak
);

    localparam int SHW = $clog2(XLEN);
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // ---------------- ALU ----------------
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] res;
    logic [SHW-1:0]  shamt;

    always_comb begin
        op1     = alu_i_op1pc  ? alu_i_pc  : alu_i_rs1;
        op2     = alu_i_op2imm ? alu_i_imm : alu_i_rs2;
        shamt   = op2[SHW-1:0];
        alu_res = '0;
        case (alu_i_op)
            4'd0:    alu_res = op1 + op2;
            4'd1:    alu_res = op1 - op2;
            4'd2:    alu_res = op1 << shamt;
            4'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            4'd4:    alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
            4'd5:    alu_res = op1 ^ op2;
            4'd6:    alu_res = op1 >> shamt;
            4'd7:    alu_res = $unsigned($signed(op1) >>> shamt);
            4'd8:    alu_res = op1 | op2;
            4'd9:    alu_res = op1 & op2;
            4'd10:   alu_res = op2;
            default: alu_res = '0;
        endcase
    end

    // nop keeps the slot (tag/ebreak still retire) but zeroes the written value
    assign res = alu_i_nop ? '0 : alu_res;

    // ---------------- result queue ----------------
    logic [XLEN-1:0] q_dat [DEPTH];
    logic [TAGW-1:0] q_tag [DEPTH];
    logic            q_ebk [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic            q_nempty;
    logic            byp_take;
    logic            out_valid;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        // explicit wrap so non-power-of-two depths work
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign q_nempty    = (count != '0);
    assign alu_i_ready = (count != FULL);

`ifdef ALU_RGLR_Q_BYPASS_EN
    logic byp;
    assign byp       = ~q_nempty & alu_i_valid & ~alu_i_flush;
    // consumed directly by writeback, so it must not also land in the queue
    assign byp_take  = byp & alu_o_ready;
    assign out_valid = q_nempty | byp;
`else
    assign byp_take  = 1'b0;
    assign out_valid = q_nempty;
`endif

    assign push = alu_i_valid & alu_i_ready & ~alu_i_flush & ~byp_take & ~rst;
    assign pop  = q_nempty & alu_o_ready;

    always_ff @(posedge clk) begin
        if (rst || alu_i_flush) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            if (push) wptr <= ptr_inc(wptr);
            if (pop)  rptr <= ptr_inc(rptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // storage needs no reset: entries are only observed while count covers them
    always_ff @(posedge clk) begin
        if (push) begin
            q_dat[wptr] <= res;
            q_tag[wptr] <= alu_i_itag;
            q_ebk[wptr] <= alu_i_ebreak;
        end
    end

    // ---------------- output mux with masking ----------------
    always_comb begin
        alu_o_valid      = out_valid;
        alu_o_wbck_wdat  = '0;
        alu_o_itag       = '0;
        alu_o_cmt_ebreak = 1'b0;
        if (q_nempty) begin
            alu_o_wbck_wdat  = q_dat[rptr];
            alu_o_itag       = q_tag[rptr];
            alu_o_cmt_ebreak = q_ebk[rptr];
        end
`ifdef ALU_RGLR_Q_BYPASS_EN
        else if (byp) begin
            alu_o_wbck_wdat  = res;
            alu_o_itag       = alu_i_itag;
            alu_o_cmt_ebreak = alu_i_ebreak;
        end
`endif
    end

endmodule
